// File: rtl/lockstep_cfg_pkg.sv
// Shared types and constants for the lockstep controller configuration initiator.
package lockstep_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  localparam logic [11:0] LOCKSTEP_MODE_OFFSET = 12'h000;
  localparam int          MODE_IF_BIT          = 0;
  localparam int          MODE_ID_BIT          = 1;
  localparam logic        OPC_OK               = 1'b0;
  localparam logic        OPC_ERR              = 1'b1;

  // A completed write that touches byte 0 of the mode register.
  function automatic logic is_mode_write(input logic wen, input logic [31:0] add,
                                         input logic [3:0] be);
    return !wen && (add[11:0] == LOCKSTEP_MODE_OFFSET) && be[0];
  endfunction

endpackage

// File: rtl/lockstep_cfg_initiator.sv
// Single-outstanding XBAR_PERIPH_BUS initiator for lockstep controller registers.
// Optional WAIT_RSP timeout is enabled by defining LOCKSTEP_INIT_TIMEOUT_EN.
module lockstep_cfg_initiator
  import lockstep_cfg_pkg::*;
#(
  parameter int unsigned          ID_WIDTH       = 2,
  parameter logic [ID_WIDTH-1:0]  INIT_ID        = '0,
  parameter int unsigned          TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_wen_i,
  input  logic [31:0]         cmd_add_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic [3:0]          cmd_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                req_o,
  output logic [31:0]         add_o,
  output logic                wen_o,
  output logic [31:0]         wdata_o,
  output logic [3:0]          be_o,
  output logic [ID_WIDTH-1:0] id_o,
  input  logic                gnt_i,
  input  logic                r_valid_i,
  input  logic                r_opc_i,
  input  logic [ID_WIDTH-1:0] r_id_i,
  input  logic [31:0]         r_rdata_i,
  output logic                mode_if_o,
  output logic                mode_id_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  state_e state, state_nxt;
  logic   rsp_hit;
  logic   rsp_capture;
  logic   tmo_abort;
  logic   tmo_hit;

  assign rsp_hit = r_valid_i && (r_id_i == INIT_ID);

`ifdef LOCKSTEP_INIT_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Held at zero outside WAIT_RSP, so it is already clear on entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || state != ST_WAIT_RSP) tmo_cnt <= '0;
    else                               tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Handshakes: cmd and rsp transfer on the edge where valid && ready; the bus
  // request transfers on req_o && gnt_i and its response on r_valid_i with r_id_i == INIT_ID.
  assign cmd_ready_o = (state == ST_IDLE);
  assign req_o       = (state == ST_REQ);
  assign rsp_valid_o = (state == ST_RESP);
  assign id_o        = INIT_ID;

  always_comb begin
    state_nxt   = state;
    rsp_capture = 1'b0;
    tmo_abort   = 1'b0;
    case (state)
      ST_IDLE: if (cmd_valid_i) state_nxt = ST_REQ;
      ST_REQ: begin
        if (gnt_i) begin
          if (rsp_hit) begin
            state_nxt   = ST_RESP;
            rsp_capture = 1'b1;
          end else begin
            state_nxt = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_hit) begin
          state_nxt   = ST_RESP;
          rsp_capture = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = ST_RESP;
          tmo_abort = 1'b1;
        end
      end
      ST_RESP: if (rsp_ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      add_o       <= '0;
      wen_o       <= 1'b1;
      wdata_o     <= '0;
      be_o        <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      mode_if_o   <= 1'b0;
      mode_id_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && cmd_valid_i) begin
        add_o   <= cmd_add_i;
        wen_o   <= cmd_wen_i;
        wdata_o <= cmd_wdata_i;
        be_o    <= cmd_be_i;
      end
      if (rsp_capture) begin
        rsp_rdata_o <= wen_o ? r_rdata_i : '0;
        rsp_err_o   <= r_opc_i;
        // Mirror tracks only writes the controller actually accepted.
        if (r_opc_i == OPC_OK && is_mode_write(wen_o, add_o, be_o)) begin
          mode_if_o <= wdata_o[MODE_IF_BIT];
          mode_id_o <= wdata_o[MODE_ID_BIT];
        end
      end else if (tmo_abort) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= OPC_ERR;
      end
    end
  end

endmodule

// File: tb/tb_lockstep_cfg_initiator.sv
// Randomized bench for lockstep_cfg_initiator with a transaction-level reference model.
module tb_lockstep_cfg_initiator;

  localparam int         ID_W = 2;
  localparam logic [1:0] INIT = 2'd0;
  localparam int         TMO  = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_wen_i = 1'b0;
  logic [31:0] cmd_add_i = '0, cmd_wdata_i = '0;
  logic [3:0]  cmd_be_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        req_o, wen_o, gnt_i = 1'b0;
  logic [31:0] add_o, wdata_o;
  logic [3:0]  be_o;
  logic [ID_W-1:0] id_o, r_id_i = '0;
  logic        r_valid_i = 1'b0, r_opc_i = 1'b0;
  logic [31:0] r_rdata_i = '0;
  logic        mode_if_o, mode_id_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_mirror = 2'b00;  // {mode_id, mode_if}

  lockstep_cfg_initiator #(.ID_WIDTH(ID_W), .INIT_ID(INIT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wen_i(cmd_wen_i),
    .cmd_add_i(cmd_add_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .req_o(req_o), .add_o(add_o), .wen_o(wen_o),
    .wdata_o(wdata_o), .be_o(be_o), .id_o(id_o), .gnt_i(gnt_i),
    .r_valid_i(r_valid_i), .r_opc_i(r_opc_i), .r_id_i(r_id_i), .r_rdata_i(r_rdata_i),
    .mode_if_o(mode_if_o), .mode_id_o(mode_id_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one complete transaction with chosen grant/response/ready timing.
  // rsp_dly counts cycles after the grant cycle before r_valid (0 = same cycle).
  task automatic run_txn(input logic wen, input logic [31:0] add, input logic [31:0] wdata,
                         input logic [3:0] be, input int gnt_dly, input int rsp_dly,
                         input int ready_dly, input logic opc, input logic [31:0] rdata,
                         input bit noise);
    int          lat;
    logic [31:0] exp_rdata;
    logic [31:0] held_rdata;
    logic [1:0]  next_mirror;
    exp_q.push_back(wen ? rdata : 32'h0);
    next_mirror = exp_mirror;
    if (!wen && !opc && add[11:0] == 12'h000 && be[0]) next_mirror = wdata[1:0];

    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready_o);
    end
    cmd_valid_i = 1'b1; cmd_wen_i = wen; cmd_add_i = add; cmd_wdata_i = wdata; cmd_be_i = be;
    step();
    lat = 1;
    cmd_valid_i = 1'b0; cmd_add_i = $urandom; cmd_wdata_i = $urandom; cmd_wen_i = ~wen;
    cmd_be_i = 4'($urandom);

    for (int g = 0; g <= gnt_dly; g++) begin
      checks++;
      if (req_o !== 1'b1 || add_o !== add || wen_o !== wen || wdata_o !== wdata ||
          be_o !== be || id_o !== INIT) begin
        errors++;
        $display("FAIL req_fields: req=%b add=%h wen=%b wdata=%h be=%h id=%0d want 1 %h %b %h %h %0d",
                 req_o, add_o, wen_o, wdata_o, be_o, id_o, add, wen, wdata, be, INIT);
      end
      gnt_i = (g == gnt_dly);
      if (g == gnt_dly && rsp_dly == 0) begin
        r_valid_i = 1'b1; r_id_i = INIT; r_opc_i = opc; r_rdata_i = rdata;
      end
      step(); lat++;
    end
    gnt_i = 1'b0; r_valid_i = 1'b0;

    for (int w = 1; w <= rsp_dly; w++) begin
      checks++;
      if (req_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
        errors++; $display("FAIL wait_rsp: req=%b rsp_valid=%b want 0 0", req_o, rsp_valid_o);
      end
      if (w == rsp_dly) begin
        r_valid_i = 1'b1; r_id_i = INIT; r_opc_i = opc; r_rdata_i = rdata;
      end else if (noise) begin
        r_valid_i = 1'b1; r_id_i = INIT ^ 2'd1; r_opc_i = 1'($urandom); r_rdata_i = $urandom;
      end
      step(); lat++;
      r_valid_i = 1'b0;
    end

    // Scoreboard
    exp_rdata = exp_q.pop_front();
    checks++;
    if (rsp_valid_o !== 1'b1 || lat != 2 + gnt_dly + rsp_dly) begin
      errors++; $display("FAIL rsp_latency: valid=%b lat=%0d want 1 %0d", rsp_valid_o, lat,
                         2 + gnt_dly + rsp_dly);
    end
    checks++;
    if (rsp_rdata_o !== exp_rdata || rsp_err_o !== opc) begin
      errors++; $display("FAIL rsp_data: rdata=%h err=%b want %h %b", rsp_rdata_o, rsp_err_o,
                         exp_rdata, opc);
    end
    checks++;
    if ({mode_id_o, mode_if_o} !== next_mirror) begin
      errors++; $display("FAIL mirror_resp: got %b want %b", {mode_id_o, mode_if_o}, next_mirror);
    end
    exp_mirror = next_mirror;
    held_rdata = rsp_rdata_o;

    for (int r = 0; r < ready_dly; r++) begin
      r_valid_i = 1'b1; r_id_i = INIT; r_opc_i = ~opc; r_rdata_i = ~rdata;
      step();
      r_valid_i = 1'b0;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_rdata || rsp_err_o !== opc) begin
        errors++; $display("FAIL rsp_hold: valid=%b rdata=%h err=%b want 1 %h %b", rsp_valid_o,
                           rsp_rdata_o, rsp_err_o, held_rdata, opc);
      end
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || {mode_id_o, mode_if_o} !== exp_mirror) begin
      errors++; $display("FAIL rsp_done: valid=%b ready=%b mirror=%b want 0 1 %b", rsp_valid_o,
                         cmd_ready_o, {mode_id_o, mode_if_o}, exp_mirror);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    checks++;
    if (req_o !== 1'b0 || rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0 ||
        add_o !== 32'h0 || wdata_o !== 32'h0 || be_o !== 4'h0 || wen_o !== 1'b1 ||
        mode_if_o !== 1'b0 || mode_id_o !== 1'b0 || id_o !== INIT || cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: req=%b rv=%b err=%b rd=%h add=%h wd=%h be=%h wen=%b m=%b%b id=%0d rdy=%b",
               req_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, add_o, wdata_o, be_o, wen_o,
               mode_id_o, mode_if_o, id_o, cmd_ready_o);
    end
    exp_mirror = 2'b00;
  endtask

  task automatic test_mode_write();
    run_txn(1'b0, 32'h0, 32'h3, 4'hF, 2, 1, 0, 1'b0, $urandom, 1'b0);
  endtask

  task automatic test_read();
    run_txn(1'b1, 32'h4, $urandom, 4'hF, 0, 1, 0, 1'b0, 32'hA5A5_0001, 1'b0);
  endtask

  task automatic test_err_write();
    run_txn(1'b0, 32'h0, 32'h1, 4'hF, 1, 1, 0, 1'b1, $urandom, 1'b0);
  endtask

  task automatic test_id_filter();
    run_txn(1'b1, 32'h8, $urandom, 4'hF, 0, 3, 3, 1'b0, 32'h1234_5678, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] add;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: add = 32'h0;
        1: add = 32'h4;
        2: add = 32'h0000_1000;
        default: add = $urandom;
      endcase
      run_txn(1'($urandom), add, $urandom, 4'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 4), $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
              $urandom, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    run_txn(1'b0, 32'h0, 32'h3, 4'h1, 0, 0, 0, 1'b0, $urandom, 1'b0);
    cmd_valid_i = 1'b1; cmd_wen_i = 1'b1; cmd_add_i = 32'h10; cmd_be_i = 4'hF;
    step();
    cmd_valid_i = 1'b0;
    checks++;
    if (req_o !== 1'b1) begin
      errors++; $display("FAIL mid_req: req=%b want 1", req_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    exp_mirror = 2'b00;
    checks++;
    if (req_o !== 1'b0 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || add_o !== 32'h0 ||
        {mode_id_o, mode_if_o} !== 2'b00) begin
      errors++; $display("FAIL mid_reset: req=%b rv=%b rdy=%b add=%h m=%b%b want 0 0 1 0 00",
                         req_o, rsp_valid_o, cmd_ready_o, add_o, mode_id_o, mode_if_o);
    end
    r_valid_i = 1'b1; r_id_i = INIT; r_opc_i = 1'b0; r_rdata_i = 32'hDEAD_BEEF;
    step();
    r_valid_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
      errors++; $display("FAIL late_rsp: rv=%b rdy=%b rd=%h want 0 1 0", rsp_valid_o,
                         cmd_ready_o, rsp_rdata_o);
    end
    run_txn(1'b1, 32'h4, 32'h0, 4'hF, 1, 2, 1, 1'b0, 32'hCAFE_0002, 1'b0);
  endtask

`ifdef LOCKSTEP_INIT_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    run_txn(1'b0, 32'h0, 32'h2, 4'h1, 0, 1, 0, 1'b0, $urandom, 1'b0);
    cmd_valid_i = 1'b1; cmd_wen_i = 1'b0; cmd_add_i = 32'h0; cmd_wdata_i = 32'h1; cmd_be_i = 4'hF;
    step();
    cmd_valid_i = 1'b0;
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    k = 0;
    while (rsp_valid_o !== 1'b1 && k < 3 * TMO) begin
      step(); k++;
    end
    checks++;
    if (rsp_valid_o !== 1'b1 || k != TMO) begin
      errors++; $display("FAIL timeout_latency: valid=%b cycles=%0d want 1 %0d", rsp_valid_o, k, TMO);
    end
    checks++;
    if (rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0 || {mode_id_o, mode_if_o} !== exp_mirror) begin
      errors++; $display("FAIL timeout_rsp: err=%b rd=%h m=%b%b want 1 0 %b", rsp_err_o,
                         rsp_rdata_o, mode_id_o, mode_if_o, exp_mirror);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    run_txn(1'b1, 32'h4, 32'h0, 4'hF, 0, 2, 0, 1'b0, 32'h0BAD_F00D, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_mode_write();
    test_read();
    test_err_write();
    test_id_filter();
    test_random();
    test_reset_mid();
`ifdef LOCKSTEP_INIT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
